// File: rtl/csr_exec.sv
// rtl/csr_exec.sv - CSR read-modify-write execute stage; define CSR_COUNTERS_EN to build mcycle/minstret
module csr_exec #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [4:0]       rs1,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [11:0]      address,
    input  logic [WIDTH-1:0] csr_rdata,
    output logic             csr_we,
    output logic [WIDTH-1:0] csr_wdata,
    input  logic             retire,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             illegal
);

    logic             accept;
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] old_val;
    logic [WIDTH-1:0] new_val;
    logic             wr_en;
    logic             op_bad;
    logic             read_only;
    logic             illegal_c;
    logic             is_cnt;

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;

    // funct3[2] selects the immediate forms, where the rs1 field is the zimm
    assign src       = funct3[2] ? {{(WIDTH-5){1'b0}}, rs1} : rs1_data;
    assign op_bad    = (funct3[1:0] == 2'b00);
    assign wr_en     = (funct3[1:0] == 2'b01) || (rs1 != 5'd0);
    assign read_only = (address[11:10] == 2'b11);
    assign illegal_c = op_bad || (wr_en && read_only);

    always_comb begin
        new_val = old_val;
        case (funct3[1:0])
            2'b01:   new_val = src;
            2'b10:   new_val = old_val | src;
            2'b11:   new_val = old_val & ~src;
            default: new_val = old_val;
        endcase
    end

    // Counter addresses are serviced internally and never reach the CSR file
    assign csr_we    = accept && !illegal_c && wr_en && !is_cnt && !reset;
    assign csr_wdata = new_val;

`ifdef CSR_COUNTERS_EN
    logic [CNT_WIDTH-1:0] mcycle;
    logic [CNT_WIDTH-1:0] minstret;
    logic [CNT_WIDTH-1:0] mcycle_nxt;
    logic [CNT_WIDTH-1:0] minstret_nxt;
    logic [CNT_WIDTH-1:0] cnt_sel;
    logic                 cnt_hi;
    logic                 cnt_ret;
    logic                 cnt_we;

    // B00/C00, B80/C80, B02/C02, B82/C82: bit 7 picks the half, bit 1 the counter
    assign is_cnt  = ((address[11:8] == 4'hB) || (address[11:8] == 4'hC))
                     && (address[6:2] == 5'd0) && !address[0];
    assign cnt_hi  = address[7];
    assign cnt_ret = address[1];
    assign cnt_we  = accept && !illegal_c && wr_en && is_cnt;

    assign cnt_sel = cnt_ret ? minstret : mcycle;
    assign old_val = is_cnt ? (cnt_hi ? cnt_sel[CNT_WIDTH-1:WIDTH] : cnt_sel[WIDTH-1:0])
                            : csr_rdata;

    // The written half takes new_val exactly; the other half keeps its increment
    always_comb begin
        mcycle_nxt   = mcycle + CNT_WIDTH'(1);
        minstret_nxt = minstret + CNT_WIDTH'(retire);
        if (cnt_we && !cnt_ret) begin
            if (cnt_hi) mcycle_nxt[CNT_WIDTH-1:WIDTH] = new_val;
            else        mcycle_nxt[WIDTH-1:0]         = new_val;
        end
        if (cnt_we && cnt_ret) begin
            if (cnt_hi) minstret_nxt[CNT_WIDTH-1:WIDTH] = new_val;
            else        minstret_nxt[WIDTH-1:0]         = new_val;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            mcycle   <= mcycle_nxt;
            minstret <= minstret_nxt;
        end
    end
`else
    logic                 unused_sig;
    logic [CNT_WIDTH-1:0] unused_cnt_w;

    assign is_cnt       = 1'b0;
    assign old_val      = csr_rdata;
    assign unused_sig   = ^{retire, address[9:0]};
    assign unused_cnt_w = '0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            rd_data   <= '0;
            illegal   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            rd_data   <= old_val;
            illegal   <= illegal_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_csr_exec.sv
// tb/tb_csr_exec.sv - scoreboard bench for csr_exec (default and CSR_COUNTERS_EN builds)
module tb_csr_exec;
    localparam int W = 32;

`ifdef CSR_COUNTERS_EN
    localparam bit HAS_CNT = 1'b1;
`else
    localparam bit HAS_CNT = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   funct3 = 3'b000;
    logic [4:0]   rs1 = 5'd0;
    logic [W-1:0] rs1_data = '0;
    logic [11:0]  address = '0;
    logic [W-1:0] csr_rdata = '0;
    logic         csr_we;
    logic [W-1:0] csr_wdata;
    logic         retire = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] rd_data;
    logic         illegal;

    csr_exec #(.WIDTH(W), .CNT_WIDTH(64)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .rs1(rs1), .rs1_data(rs1_data), .address(address),
        .csr_rdata(csr_rdata), .csr_we(csr_we), .csr_wdata(csr_wdata),
        .retire(retire), .out_valid(out_valid), .out_ready(out_ready),
        .rd_data(rd_data), .illegal(illegal)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_pass = 0;
    logic [W:0]  sb[$];
    logic [63:0] cyc;

    // Free-running cycle count since reset release: the expected mcycle when unwritten
    always @(posedge clock or posedge reset) begin
        if (reset) cyc <= '0;
        else       cyc <= cyc + 64'd1;
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] pick(input logic [W-1:0] c, input logic [W-1:0] r);
        return HAS_CNT ? c : r;
    endfunction

    initial begin
        logic [W:0] e;
        forever begin
            @(negedge clock);
            #1;
            if (!reset && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rd_data", rd_data, e[W-1:0]);
                    check("illegal", W'(illegal), W'(e[W]));
                end
            end
        end
    end

    // src: 0 = exp_rd as given, 1 = mcycle low from model, 2 = mcycle high from model
    task automatic issue(input logic [2:0] f, input logic [4:0] r, input logic [W-1:0] d,
                         input logic [11:0] a, input logic [W-1:0] rdat, input logic exp_we,
                         input logic [W-1:0] exp_wd, input int src, input logic [W-1:0] exp_rd,
                         input logic exp_ill, output int waited);
        logic [W-1:0] e;
        @(negedge clock);
        funct3 = f; rs1 = r; rs1_data = d; address = a; csr_rdata = rdat;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        waited = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clock);
            #1;
            waited++;
        end
        if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
        check("csr_we", W'(csr_we), W'(exp_we));
        if (exp_we) check("csr_wdata", csr_wdata, exp_wd);
        case (src)
            1:       e = cyc[W-1:0];
            2:       e = cyc[63:W];
            default: e = exp_rd;
        endcase
        sb.push_back({exp_ill, e});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            in_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        #1 reset = 1'b1;
        funct3 = 3'b001; rs1 = 5'd1; rs1_data = 32'hDEADBEEF; address = 12'h340; in_valid = 1'b1;
        #12;
        check("reset_csr_we", W'(csr_we), 32'd0);
        check("reset_out_valid", W'(out_valid), 32'd0);
        check("reset_rd_data", rd_data, 32'd0);
        check("reset_illegal", W'(illegal), 32'd0);
        @(negedge clock);
        in_valid = 1'b0;
        reset = 1'b0;

        issue(3'b001, 5'd1, 32'hDEADBEEF, 12'h340, 32'h12345678, 1, 32'hDEADBEEF, 0, 32'h12345678, 0, w);
        idle(1);
        #1 check("rw_out_valid", W'(out_valid), 32'd1);
        issue(3'b011, 5'd5, 32'h0000000F, 12'h341, 32'h000000FF, 1, 32'h000000F0, 0, 32'h000000FF, 0, w);
        issue(3'b010, 5'd0, 32'hFFFFFFFF, 12'h300, 32'h000000AB, 0, 32'h0, 0, 32'h000000AB, 0, w);
        issue(3'b110, 5'h1F, 32'hFFFFFFFF, 12'h300, 32'h00000100, 1, 32'h0000011F, 0, 32'h00000100, 0, w);
        issue(3'b111, 5'd3, 32'h0, 12'h300, 32'h0000000F, 1, 32'h0000000C, 0, 32'h0000000F, 0, w);
        issue(3'b101, 5'd0, 32'h0, 12'h305, 32'h00000042, 1, 32'h00000000, 0, 32'h00000042, 0, w);
        issue(3'b000, 5'd1, 32'h1, 12'h340, 32'h00000011, 0, 32'h0, 0, 32'h00000011, 1, w);
        issue(3'b100, 5'd1, 32'h1, 12'h340, 32'h00000022, 0, 32'h0, 0, 32'h00000022, 1, w);
        issue(3'b001, 5'd1, 32'h5, 12'hC00, 32'h00001111, 0, 32'h0, HAS_CNT ? 1 : 0, 32'h00001111, 1, w);
        issue(3'b010, 5'd0, 32'h5, 12'hC00, 32'h00002222, 0, 32'h0, HAS_CNT ? 1 : 0, 32'h00002222, 0, w);
        issue(3'b010, 5'd3, 32'h5, 12'hC10, 32'h00003333, 0, 32'h0, 0, 32'h00003333, 1, w);
        issue(3'b001, 5'd2, 32'h0000CAFE, 12'hB03, 32'h00004444, 1, 32'h0000CAFE, 0, 32'h00004444, 0, w);

        // Stall: hold the result for 3 cycles while a new request waits
        idle(2);
        issue(3'b001, 5'd1, 32'h00000055, 12'h341, 32'h0000A5A5, 1, 32'h00000055, 0, 32'h0000A5A5, 0, w);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            funct3 = 3'b001; rs1 = 5'd1; rs1_data = 32'h66; address = 12'h342; csr_rdata = 32'h5A5A;
            in_valid = 1'b1;
            #1;
            check("stall_in_ready", W'(in_ready), 32'd0);
            check("stall_csr_we", W'(csr_we), 32'd0);
            check("stall_out_valid", W'(out_valid), 32'd1);
            check("stall_rd_data", rd_data, 32'h0000A5A5);
        end
        issue(3'b001, 5'd1, 32'h66, 12'h342, 32'h5A5A, 1, 32'h66, 0, 32'h5A5A, 0, w);
        check("b2b_wait", W'(w), 32'd0);

        // Counter half writes and wrap
        idle(2);
        issue(3'b001, 5'd1, 32'hFFFFFFFF, 12'hB80, 32'h0BAD0080, !HAS_CNT, 32'hFFFFFFFF,
              HAS_CNT ? 2 : 0, 32'h0BAD0080, 0, w);
        issue(3'b001, 5'd1, 32'hFFFFFFFF, 12'hB00, 32'h0BAD0000, !HAS_CNT, 32'hFFFFFFFF,
              HAS_CNT ? 1 : 0, 32'h0BAD0000, 0, w);
        issue(3'b010, 5'd0, 32'h0, 12'hC00, 32'h00C0C000, 0, 32'h0, 0, pick(32'hFFFFFFFF, 32'h00C0C000), 0, w);
        issue(3'b010, 5'd0, 32'h0, 12'hC80, 32'h00C0C080, 0, 32'h0, 0, pick(32'h00000000, 32'h00C0C080), 0, w);
        issue(3'b010, 5'd0, 32'h0, 12'hC00, 32'h00C0C001, 0, 32'h0, 0, pick(32'h00000001, 32'h00C0C001), 0, w);

        // Retire for exactly 10 rising edges
        idle(1);
        retire = 1'b1;
        repeat (10) @(negedge clock);
        retire = 1'b0;
        issue(3'b010, 5'd0, 32'h0, 12'hC02, 32'h00D0D002, 0, 32'h0, 0, pick(32'd10, 32'h00D0D002), 0, w);
        issue(3'b010, 5'd0, 32'h0, 12'hC82, 32'h00D0D082, 0, 32'h0, 0, pick(32'd0, 32'h00D0D082), 0, w);

        // Reset while a result is held
        idle(2);
        issue(3'b001, 5'd1, 32'h1, 12'h343, 32'h00000077, 1, 32'h1, 0, 32'h00000077, 0, w);
        out_ready = 1'b0;
        idle(1);
        #1 check("held_out_valid", W'(out_valid), 32'd1);
        #2 reset = 1'b1;
        sb.delete();
        #1;
        check("async_out_valid", W'(out_valid), 32'd0);
        check("async_rd_data", rd_data, 32'd0);
        check("async_illegal", W'(illegal), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        out_ready = 1'b1;
        issue(3'b010, 5'd0, 32'h0, 12'hC00, 32'h00E0E000, 0, 32'h0, 0, pick(32'd1, 32'h00E0E000), 0, w);
        issue(3'b010, 5'd0, 32'h0, 12'hC02, 32'h00E0E002, 0, 32'h0, 0, pick(32'd0, 32'h00E0E002), 0, w);

        idle(4);
        check("sb_empty", W'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
